xadc_phase_sequencer: RTL
=========================

// Module: xadc_phase_sequencer
// PURPOSE
// Sequences single-channel XADC DRP reads against the switching PWM to
// demodulate the switched signal. Each PWM edge starts a new phase.
// After a settle delay the block averages 2^AVG_LOG2 conversions per phase.
// demod = ON average - OFF average.
// Sits between the XADC wizard's DRP port and the downstream demod consumer.
// It replaces free-running eoc->den chaining.
// PARAMETERS
// DRP_ADDR        7'h10  DRP register read each request (VAUX0 status)
// SETTLE_CYCLES   64     clk cycles waited after a PWM edge before the first read (>=1)
// TIMEOUT_CYCLES  255    max clk cycles in WAIT for drdy before abort (>=1)
// AVG_LOG2        2      log2 of samples averaged per phase (0..4)
// PORTS
// clk          in   1   system clock; all logic posedge
// reset        in   1   asynchronous, active-high reset
// switch_pwm   in   1   switching PWM, asynchronous to clk
// drp_daddr    out  7   DRP address; DRP_ADDR whenever drp_den=1, else 0
// drp_den      out  1   DRP read enable, single-cycle pulse
// drp_do       in   16  DRP read data; sample = drp_do[15:4]
// drp_drdy     in   1   DRP data valid, single-cycle
// demod        out  13  signed ON-OFF difference, held until next update
// demod_valid  out  1   one-cycle pulse when demod updates
// timeout_err  out  1   sticky: a drdy timeout occurred; cleared only by reset
// busy         out  1   high in any state other than IDLE
// BEHAVIOUR
// - Reset:
//   - state=IDLE; all outputs 0.
//   - on_reg, off_reg, accumulator, counters and on_valid all cleared.
// - switch_pwm passes through a 2-flop synchronizer, then a registered edge detector.
//   - rise -> phase ON; fall -> phase OFF.
// - States: IDLE, SETTLE, REQ, WAIT.
// - Edge detected in cycle t, from any state:
//   - Set phase, clear accumulator and sample count.
//   - Enter SETTLE at t+1 with counter=0.
//   - An edge mid-phase aborts the current phase; partial data is discarded.
//   - An edge during WAIT also discards the pending drdy.
// - SETTLE: count to SETTLE_CYCLES, then REQ.
//   - Without intervening edges, first drp_den is high in cycle t+1+SETTLE_CYCLES.
// - REQ: drp_den=1 and drp_daddr=DRP_ADDR for exactly one cycle, then WAIT.
//   - Only one read is ever outstanding.
// - WAIT: on drp_drdy:
//   - acc += drp_do[15:4] (acc width 12+AVG_LOG2, never overflows).
//   - count++.
//   - If count == 2^AVG_LOG2: result = acc >> AVG_LOG2 (truncate).
//     - Phase ON: store to on_reg, set on_valid.
//     - Phase OFF: store to off_reg.
//     - Then go to IDLE.
//   - Otherwise return to REQ on the next cycle.
// - Output rule: when an OFF result is stored and on_valid=1:
//   - Next cycle: demod = {1'b0,on_reg} - {1'b0,off_reg} (signed 13-bit), demod_valid=1.
//   - on_valid is cleared.
//   - An OFF completion with on_valid=0 produces no output.
// - on_valid is cleared whenever an ON phase is aborted.
// - drp_drdy outside WAIT is ignored.
// - Timeout: TIMEOUT_CYCLES cycles in WAIT without drdy:
//   - Set timeout_err; abort the phase (discard; clear on_valid if phase ON).
//   - Go to IDLE.
// - Edge and drdy in the same cycle: the edge wins; the sample is discarded.
// - Reset mid-operation: drp_den drops immediately (async).
//   - A drdy arriving after reset release is ignored (state IDLE).
// TESTING
// Bench params: SETTLE=4, AVG_LOG2=2, TIMEOUT=16. The DRP model answers drdy 3 cycles after den.
// - Basic: ON phase returns drp_do=16'h8000 x4, OFF returns 16'h3000 x4.
//   - Required: demod=13'sd1280, one demod_valid pulse.
//   - Required: first den exactly SETTLE+1 cycles after the synced edge.
// - Negative: ON 16'h1000 x4, OFF 16'h4000 x4 -> demod=-768 (13'h1D00).
// - Truncation: ON samples 1,2,2,2 -> on_reg=1; OFF samples 0 x4 -> demod=1.
// - Timeout: model withholds drdy in ON phase.
//   - Required: timeout_err=1 after 16 WAIT cycles, busy=0.
//   - Required: the following OFF phase produces no demod_valid.
//   - Required: the next full ON/OFF pair produces output; timeout_err stays 1.
// - Early edge: PWM falls after 2 of 4 ON samples.
//   - Required: ON discarded, OFF completes, no demod_valid.
//   - Required: den never asserted while a read is outstanding.
// - Reset in WAIT: drp_den=0 and all outputs 0 immediately.
//   - Required: late drdy causes no accumulator change and no demod_valid.

Source files
------------

// File: rtl/xadc_phase_sequencer.sv
// PWM-synchronous XADC DRP reader: averages each switching phase
// and reports ON minus OFF as a signed demodulated value.
`timescale 1ns/1ps
module xadc_phase_sequencer #(
  parameter logic [6:0] DRP_ADDR = 7'h10,
  parameter int SETTLE_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int AVG_LOG2 = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               switch_pwm,
  output logic [6:0]         drp_daddr,
  output logic               drp_den,
  input  logic [15:0]        drp_do,
  input  logic               drp_drdy,
  output logic signed [12:0] demod,
  output logic               demod_valid,
  output logic               timeout_err,
  output logic               busy
);

  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] NSAMP = CW'(1 << AVG_LOG2);

  typedef enum logic [1:0] {IDLE, SETTLE, REQ, WAIT} state_t;

  state_t state, state_nxt;

  logic sync1, sync2, sync_d;
  logic edge_any, rise;
  logic phase;
  logic [AW-1:0] acc, acc_sum;
  logic [CW-1:0] cnt, cnt_inc;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic [11:0] on_reg, off_reg, result;
  logic on_valid, pend;
  logic take, done, tmo;
  logic drp_do_unused;

  assign drp_do_unused = ^drp_do[3:0];
  assign edge_any = sync2 ^ sync_d;
  assign rise = sync2 & ~sync_d;
  assign acc_sum = acc + AW'(drp_do[15:4]);
  assign cnt_inc = cnt + 1'b1;
  assign result = acc_sum[AW-1:AVG_LOG2];

  assign drp_den = (state == REQ);
  assign drp_daddr = drp_den ? DRP_ADDR : 7'h0;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end

  // An edge overrides whatever the current state would do,
  // including a drdy arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    take = 1'b0;
    done = 1'b0;
    tmo = 1'b0;
    if (edge_any) begin
      state_nxt = SETTLE;
    end else begin
      unique case (state)
        IDLE: state_nxt = IDLE;
        SETTLE:
          if (scnt == SW'(SETTLE_CYCLES - 1)) state_nxt = REQ;
        REQ: state_nxt = WAIT;
        WAIT:
          if (drp_drdy) begin
            take = 1'b1;
            if (cnt_inc == NSAMP) begin
              done = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = REQ;
            end
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo = 1'b1;
            state_nxt = IDLE;
          end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1 <= switch_pwm;
      sync2 <= sync1;
      sync_d <= sync2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 1'b0;
      acc <= '0;
      cnt <= '0;
      scnt <= '0;
      tcnt <= '0;
      on_reg <= '0;
      off_reg <= '0;
      on_valid <= 1'b0;
      pend <= 1'b0;
      demod <= '0;
      demod_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      demod_valid <= 1'b0;
      if (pend) begin
        demod <= {1'b0, on_reg} - {1'b0, off_reg};
        demod_valid <= 1'b1;
        on_valid <= 1'b0;
        pend <= 1'b0;
      end
      if (edge_any) begin
        phase <= rise;
        acc <= '0;
        cnt <= '0;
        scnt <= '0;
        if (phase && state != IDLE) on_valid <= 1'b0;
      end else begin
        if (state == SETTLE) scnt <= scnt + 1'b1;
        if (state == REQ) tcnt <= '0;
        if (state == WAIT && !drp_drdy) tcnt <= tcnt + 1'b1;
        if (take) begin
          acc <= acc_sum;
          cnt <= cnt_inc;
        end
        if (done && phase) begin
          on_reg <= result;
          on_valid <= 1'b1;
        end
        if (done && !phase) begin
          off_reg <= result;
          if (on_valid) pend <= 1'b1;
        end
        if (tmo) begin
          timeout_err <= 1'b1;
          if (phase) on_valid <= 1'b0;
        end
      end
    end
  end

endmodule
